// File: rtl/phase_countdown_timer.sv
// phase_countdown_timer: loadable down-counter for traffic-light phase durations.
//   Counts a loaded duration (0..MAX_COUNT) down on an internal CLK_DIV prescaler,
//   pulses expired for one clk at completion, supports pause/abort.
// Ports:
//   clk, reset (async, active-high)
//   load_valid/load_ready/load_value : duration handshake, accepted only in IDLE
//   pause, abort                     : level controls, abort has priority
//   remaining, tens, ones            : ticks left, binary and two BCD digits
//   busy, tick, expired              : status strobes
module phase_countdown_timer #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_COUNT = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [6:0] load_value,
  input  logic       pause,
  input  logic       abort,
  output logic [6:0] remaining,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       busy,
  output logic       tick,
  output logic       expired
);

  localparam int              PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [6:0]      MAX_V    = 7'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    EXPIRE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    remaining_q, remaining_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic          expired_q, expired_d;
  logic [6:0]    load_clamped;

  // Clamp on the way in so no value above MAX_COUNT is ever stored.
  assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;

  // Combinational strobe: only fires when the decrement will really happen.
  assign tick = (state_q == RUN) && (prescaler_q == PRE_LAST) && !pause && !abort;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prescaler_d = prescaler_q;
    expired_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          remaining_d = load_clamped;
          prescaler_d = '0;
          if (load_clamped == 7'd0) begin
            state_d   = EXPIRE;
            expired_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
          prescaler_d = '0;
        end else if (pause) begin
          // Prescaler holds so the phase resumes exactly where it stopped.
          state_d = PAUSED;
        end else if (prescaler_q == PRE_LAST) begin
          prescaler_d = '0;
          if (remaining_q == 7'd1) begin
            remaining_d = '0;
            state_d     = EXPIRE;
            expired_d   = 1'b1;
          end else begin
            remaining_d = remaining_q - 7'd1;
          end
        end else begin
          prescaler_d = prescaler_q + PW'(1);
        end
      end
      PAUSED: begin
        if (abort) begin
          state_d     = IDLE;
          remaining_d = '0;
          prescaler_d = '0;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      EXPIRE: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
        prescaler_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      prescaler_q <= '0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      prescaler_q <= prescaler_d;
      expired_q   <= expired_d;
    end
  end

  assign remaining  = remaining_q;
  assign expired    = expired_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == RUN) || (state_q == PAUSED);
  assign tens       = 4'(remaining_q / 7'd10);
  assign ones       = 4'(remaining_q % 7'd10);

endmodule

// File: tb/tb_phase_countdown_timer.sv
module tb_phase_countdown_timer;

  localparam int CLK_DIV   = 4;
  localparam int MAX_COUNT = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [6:0] load_value;
  logic       pause;
  logic       abort;
  logic [6:0] remaining;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       busy;
  logic       tick;
  logic       expired;

  int n_checks = 0;
  int n_fail   = 0;

  phase_countdown_timer #(.CLK_DIV(CLK_DIV), .MAX_COUNT(MAX_COUNT)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_ready(load_ready), .load_value(load_value),
    .pause(pause), .abort(abort),
    .remaining(remaining), .tens(tens), .ones(ones),
    .busy(busy), .tick(tick), .expired(expired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [6:0] val;
    logic       p;
    logic       a;
    int         rem;
    logic       t;
    logic       x;
    logic       rdy;
    logic       b;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [6:0] v, input logic p, input logic a);
    load_valid = lv;
    load_value = v;
    pause      = p;
    abort      = a;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 7'd0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic vec_t mk(logic lv, int v, logic p, logic a, int rem,
                              logic t, logic x, logic rdy, logic b);
    vec_t r;
    r.lv = lv; r.val = 7'(v); r.p = p; r.a = a; r.rem = rem;
    r.t = t; r.x = x; r.rdy = rdy; r.b = b;
    return r;
  endfunction

  // Reference model: counts "active" cycles (RUN, pause/abort low, not the
  // resume cycle) and decrements after every CLK_DIV of them.
  int m_rem, m_cnt;
  bit m_run, m_held, m_exp;

  task automatic model_reset();
    m_rem = 0; m_cnt = 0; m_run = 0; m_held = 0; m_exp = 0;
  endtask

  task automatic model_edge();
    if (m_exp) begin
      m_exp = 0;
    end else if (!m_run) begin
      if (load_valid) begin
        m_rem = (int'(load_value) > MAX_COUNT) ? MAX_COUNT : int'(load_value);
        m_cnt = 0;
        if (m_rem == 0) m_exp = 1;
        else begin m_run = 1; m_held = 0; end
      end
    end else if (abort) begin
      m_run = 0; m_rem = 0; m_cnt = 0; m_held = 0;
    end else if (pause) begin
      m_held = 1;
    end else if (m_held) begin
      m_held = 0;
    end else begin
      m_cnt++;
      if (m_cnt == CLK_DIV) begin
        m_cnt = 0;
        m_rem--;
        if (m_rem == 0) begin m_run = 0; m_exp = 1; end
      end
    end
  endtask

  initial begin
    int edge_cnt;
    int exp_edge;
    bit seen;

    // Table: load 3, load 0, load 120 (clamp + BCD), then abort.
    vecs.push_back(mk(1, 3, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 3, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 120, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 99, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 99, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 99, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 99, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 98, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));

    do_reset();
    check("reset_remaining", remaining, 0);
    check("reset_bcd", {tens, ones}, 0);
    check("reset_flags", {busy, tick, expired, load_ready}, 4'b0001);

    foreach (vecs[i]) begin
      drive(vecs[i].lv, vecs[i].val, vecs[i].p, vecs[i].a);
      #1;
      check($sformatf("vec%0d_rem", i), remaining, vecs[i].rem);
      check($sformatf("vec%0d_tens", i), tens, vecs[i].rem / 10);
      check($sformatf("vec%0d_ones", i), ones, vecs[i].rem % 10);
      check($sformatf("vec%0d_flags", i), {busy, tick, expired, load_ready},
            {vecs[i].b, vecs[i].t, vecs[i].x, vecs[i].rdy});
      step();
    end

    // Reset mid-RUN at remaining=37: outputs clear without waiting for a clock.
    do_reset();
    drive(1, 7'd40, 0, 0);
    step();
    drive(0, 7'd0, 0, 0);
    repeat (3 * CLK_DIV) step();
    check("rst_mid_pre", remaining, 37);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_rem", remaining, 0);
    check("rst_mid_flags", {busy, tick, expired, load_ready}, 4'b0001);
    check("rst_mid_bcd", {tens, ones}, 0);
    seen = 0;
    repeat (3) begin step(); if (expired) seen = 1; end
    reset = 1'b0;
    repeat (3) begin step(); if (expired) seen = 1; end
    check("rst_mid_no_expired", seen, 0);

    // Load 5, stall: pause high 9 cycles plus the resume cycle = 10 lost clocks.
    do_reset();
    drive(1, 7'd5, 0, 0);
    step();                       // edge 0 accepted
    drive(0, 7'd0, 0, 0);
    edge_cnt = 0;
    repeat (6) begin step(); edge_cnt++; end
    check("pause_pre_rem", remaining, 4);
    pause = 1'b1;
    seen = 0;
    repeat (9) begin
      #1;
      if (tick) seen = 1;
      step(); edge_cnt++;
      if (remaining != 7'd4) seen = 1;
    end
    check("pause_frozen", seen, 0);
    pause = 1'b0;
    exp_edge = -1;
    for (int k = 0; k < 60 && exp_edge < 0; k++) begin
      step(); edge_cnt++;
      if (expired) exp_edge = edge_cnt;
    end
    check("pause_expire_edge", exp_edge, 5 * CLK_DIV + 10);
    step();
    check("pause_expire_1clk", {expired, load_ready}, 2'b01);

    // Load 5, abort at remaining=2, reload on the following edge.
    do_reset();
    drive(1, 7'd5, 0, 0);
    step();
    drive(0, 7'd0, 0, 0);
    repeat (3 * CLK_DIV) step();
    check("abort_pre_rem", remaining, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rem", remaining, 0);
    check("abort_flags", {busy, expired, load_ready}, 3'b001);
    drive(1, 7'd7, 0, 0);
    step();
    drive(0, 7'd0, 0, 0);
    check("abort_reload", {busy, remaining}, {1'b1, 7'd7});

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 9) < 3,
            ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 6)),
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 39) == 0);
      #1;
      check("rnd_rem", remaining, m_rem);
      check("rnd_bcd", {tens, ones}, {4'(m_rem / 10), 4'(m_rem % 10)});
      check("rnd_flags", {busy, tick, expired, load_ready},
            {m_run, m_run && !m_held && !pause && !abort && (m_cnt == CLK_DIV - 1),
             m_exp, !m_run && !m_exp});
      model_edge();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
